gpu_bus_sender: RTL and testbench

//  Host-side initiator for the GPU 8-bit command bus (i_we/i_en/i_data/ack).

---
 rtl/gpu_bus_pkg.sv | 38 +++
 rtl/gpu_bus_byte_tx.sv | 87 ++++++++
 rtl/gpu_bus_sender.sv | 106 ++++++++++
 tb/tb_gpu_bus_sender.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_bus_pkg.sv
// Shared definitions for the GPU 8-bit command bus: opcodes, field widths,
// frame sizes and the byte-handshake state encoding. The instruction decoder
// on the GPU side uses the same package.
package gpu_bus_pkg;

  localparam int X_W     = 10;
  localparam int Y_W     = 10;
  localparam int COLOR_W = 12;
  localparam int MODE_W  = 8;

  // Widest frame is SET_PIXEL: opcode byte plus 32 payload bits.
  localparam int FRAME_W = 40;

  localparam logic [7:0] OP_SET_MODE  = 8'h01;
  localparam logic [7:0] OP_SET_PIXEL = 8'h02;

  localparam logic [2:0] MODE_BYTES  = 3'd2;
  localparam logic [2:0] PIXEL_BYTES = 3'd5;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_DRIVE   = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_e;

  // Frames are left-aligned so the byte on the bus is always the top byte.
  function automatic logic [FRAME_W-1:0] pack_mode(input logic [MODE_W-1:0] mode);
    return {OP_SET_MODE, mode, 24'h000000};
  endfunction

  function automatic logic [FRAME_W-1:0] pack_pixel(input logic [X_W-1:0]     x,
                                                    input logic [Y_W-1:0]     y,
                                                    input logic [COLOR_W-1:0] color);
    return {OP_SET_PIXEL, x, y, color};
  endfunction

endpackage

// File: rtl/gpu_bus_byte_tx.sv
// Single-byte 4-phase handshake engine: DRIVE -> WAIT_HI -> WAIT_LO.
// start_i launches a byte from idle; more_i chains straight into the next
// byte when the current one completes. done_o pulses on the edge a byte
// finishes. Optional timeout (macro GPU_TX_TIMEOUT_EN) pulses abort_o when
// either wait state lasts TIMEOUT_CYCLES cycles.
module gpu_bus_byte_tx
  import gpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic more_i,
  input  logic ack_i,
  output logic en_o,
  output logic done_o,
  output logic abort_o
);

  tx_state_e state_q, state_d;

`ifdef GPU_TX_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timer_q, timer_d;
  logic        waiting;

  assign waiting = (state_q == TX_WAIT_HI) || (state_q == TX_WAIT_LO);
`endif

  // Next-state logic for one byte's handshake, plus the optional abort.
  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    abort_o = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start_i) state_d = TX_DRIVE;
      end
      TX_DRIVE: begin
        state_d = TX_WAIT_HI;
      end
      TX_WAIT_HI: begin
        if (ack_i) state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!ack_i) begin
          done_o  = 1'b1;
          state_d = more_i ? TX_DRIVE : TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
`ifdef GPU_TX_TIMEOUT_EN
    if (waiting && (state_d == state_q) && (timer_q == TIMER_LAST)) begin
      abort_o = 1'b1;
      state_d = TX_IDLE;
    end
`endif
  end

  // en is high from DRIVE until the ack is seen, so it drops with reset too.
  assign en_o = (state_q == TX_DRIVE) || (state_q == TX_WAIT_HI);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= TX_IDLE;
    else          state_q <= state_d;
  end

`ifdef GPU_TX_TIMEOUT_EN
  // Wait timer restarts on every state change and only runs while waiting.
  always_comb begin
    timer_d = 16'd0;
    if (waiting && (state_d == state_q)) timer_d = timer_q + 16'd1;
  end

  // Timer register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) timer_q <= 16'd0;
    else          timer_q <= timer_d;
  end
`endif

endmodule

// File: rtl/gpu_bus_sender.sv
// Host-side initiator for the GPU command bus. Accepts SET_MODE / SET_PIXEL
// commands on a valid/ready port and serialises them MSB-first as bytes,
// each using the 4-phase handshake in gpu_bus_byte_tx.
// Optional feature macro: GPU_TX_TIMEOUT_EN (ack timeout with sticky o_err).
module gpu_bus_sender
  import gpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_op,
  input  logic [MODE_W-1:0]  i_mode,
  input  logic [X_W-1:0]     i_pixel_x,
  input  logic [Y_W-1:0]     i_pixel_y,
  input  logic [COLOR_W-1:0] i_color,
  output logic               o_we,
  output logic               o_en,
  output logic [7:0]         o_data,
  input  logic               i_ack,
  output logic               o_busy,
  output logic               o_err
);

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               ready_q;
  logic               accept;
  logic               more;
  logic               tx_en;
  logic               tx_done;
  logic               tx_abort;

  assign accept = i_cmd_valid && ready_q;
  assign more   = (cnt_q > 3'd1);

  gpu_bus_byte_tx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_byte_tx (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .start_i (accept),
    .more_i  (more),
    .ack_i   (i_ack),
    .en_o    (tx_en),
    .done_o  (tx_done),
    .abort_o (tx_abort)
  );

  // Load the frame on accept, shift one byte out per completed handshake.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (i_cmd_op) begin
        shift_d = pack_pixel(i_pixel_x, i_pixel_y, i_color);
        cnt_d   = PIXEL_BYTES;
      end else begin
        shift_d = pack_mode(i_mode);
        cnt_d   = MODE_BYTES;
      end
    end else if (tx_abort) begin
      shift_d = '0;
      cnt_d   = 3'd0;
    end else if (tx_done) begin
      shift_d = {shift_q[FRAME_W-9:0], 8'h00};
      cnt_d   = cnt_q - 3'd1;
    end
  end

  // Frame registers; ready follows "nothing left to send" one cycle later,
  // so it is low during reset and rises the first cycle after release.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_q <= '0;
      cnt_q   <= 3'd0;
      ready_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d == 3'd0);
    end
  end

`ifdef GPU_TX_TIMEOUT_EN
  logic err_q;

  // Sticky error: any aborted handshake latches it until reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      err_q <= 1'b0;
    else if (tx_abort) err_q <= 1'b1;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_en        = tx_en;
  assign o_we        = tx_en;
  assign o_data      = shift_q[FRAME_W-1:FRAME_W-8];
  assign o_cmd_ready = ready_q;
  assign o_busy      = ~ready_q;

endmodule

// File: tb/tb_gpu_bus_sender.sv
// Bench for gpu_bus_sender: a configurable GPU ack responder, a bus monitor
// that records every byte strobed, and a byte-level model of the framing.
module tb_gpu_bus_sender;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cmdValid;
  logic        cmdOp;
  logic [7:0]  mode;
  logic [9:0]  pixelX;
  logic [9:0]  pixelY;
  logic [11:0] color;
  logic        ack;
  logic        cmdReady;
  logic        we;
  logic        en;
  logic [7:0]  data;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;

  logic [7:0] expQ[$];
  logic [7:0] seenQ[$];
  int   enRises = 0;
  int   unstable = 0;
  int   weMismatch = 0;
  logic prevEn = 1'b0;
  logic [7:0] holdData = 8'h00;

  int riseDelay = 1;
  int fallDelay = 1;
  int hiCnt = 0;
  int loCnt = 0;
  bit ackNever = 1'b0;
  bit ackForceHigh = 1'b0;

  gpu_bus_sender #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_cmd_valid (cmdValid),
    .o_cmd_ready (cmdReady),
    .i_cmd_op    (cmdOp),
    .i_mode      (mode),
    .i_pixel_x   (pixelX),
    .i_pixel_y   (pixelY),
    .i_color     (color),
    .o_we        (we),
    .o_en        (en),
    .o_data      (data),
    .i_ack       (ack),
    .o_busy      (busy),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // GPU responder: raises ack after en has been seen high riseDelay times,
  // drops it after en has been seen low fallDelay times.
  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (en === 1'b1) begin hiCnt++; loCnt = 0; end
      else begin loCnt++; hiCnt = 0; end
      if (ackForceHigh) ack = 1'b1;
      else if (ackNever) ack = 1'b0;
      else if (en === 1'b1 && hiCnt >= riseDelay) ack = 1'b1;
      else if (en !== 1'b1 && loCnt >= fallDelay) ack = 1'b0;
    end
  end

  // Bus monitor: logs each byte on the rising of en and watches stability.
  initial begin
    forever begin
      @(negedge clk);
      if (en === 1'b1 && prevEn !== 1'b1) begin
        seenQ.push_back(data);
        enRises++;
        holdData = data;
      end else if (en === 1'b1 && data !== holdData) begin
        unstable++;
      end
      if (we !== en) weMismatch++;
      prevEn = en;
    end
  end

  // Expected bus bytes for one command, built from the framing rules.
  task automatic push_expected(input logic op, input logic [7:0] m, input logic [9:0] x,
                               input logic [9:0] y, input logic [11:0] c);
    longint unsigned word;
    if (!op) begin
      expQ.push_back(8'h01);
      expQ.push_back(m);
    end else begin
      word = longint'(x) * 64'd4194304 + longint'(y) * 64'd4096 + longint'(c);
      expQ.push_back(8'h02);
      for (int k = 3; k >= 0; k--) expQ.push_back(8'((word >> (8 * k)) & 64'hFF));
    end
  endtask

  task automatic issue_cmd(input logic op, input logic [7:0] m, input logic [9:0] x,
                           input logic [9:0] y, input logic [11:0] c, input bit keepValid,
                           output int acceptAt);
    cmdOp = op; mode = m; pixelX = x; pixelY = y; color = c;
    cmdValid = 1'b1;
    acceptAt = -1;
    for (int i = 0; i < 300; i++) begin
      if (cmdReady === 1'b1) begin
        acceptAt = cycleCount + 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (acceptAt < 0) begin
      failures++;
      $display("[TB] FAIL accept_timeout: ready=%b required=1", cmdReady);
    end else begin
      push_expected(op, m, x, y, c);
    end
    @(negedge clk);
    if (!keepValid) cmdValid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cmdReady === 1'b1 && en === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s_idle_timeout: ready=%b en=%b required ready=1 en=0", tag, cmdReady, en);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_queues();
    expQ.delete();
    seenQ.delete();
  endtask

  task automatic test_reset();
    rstN = 1'b0; cmdValid = 1'b0; cmdOp = 1'b0; mode = '0; pixelX = '0; pixelY = '0; color = '0;
    repeat (3) @(negedge clk);
    checks++; if (en !== 1'b0) begin failures++; $display("[TB] FAIL reset_en: got %b want 0", en); end
    checks++; if (we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b want 0", we); end
    checks++; if (data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h want 00", data); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b want 0", cmdReady); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
    rstN = 1'b1;
    @(negedge clk);
    checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready: got %b want 1", cmdReady); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
    clear_queues();
  endtask

  task automatic test_set_mode();
    int acc;
    riseDelay = 2; fallDelay = 1;
    clear_queues();
    issue_cmd(1'b0, 8'h03, 10'h0, 10'h0, 12'h0, 1'b0, acc);
    wait_idle("set_mode");
    checks++;
    if (seenQ.size() != 2) begin
      failures++; $display("[TB] FAIL set_mode_count: got %0d bytes want 2", seenQ.size());
    end else begin
      checks++; if (seenQ[0] !== 8'h01) begin failures++; $display("[TB] FAIL set_mode_b0: got %h want 01", seenQ[0]); end
      checks++; if (seenQ[1] !== 8'h03) begin failures++; $display("[TB] FAIL set_mode_b1: got %h want 03", seenQ[1]); end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL set_mode_err: got %b want 0", err); end
  endtask

  task automatic test_set_pixel();
    int acc;
    logic [7:0] golden[5];
    golden = '{8'h02, 8'hFF, 8'hC0, 8'h1A, 8'hBC};
    riseDelay = 2; fallDelay = 2;
    clear_queues();
    issue_cmd(1'b1, 8'h00, 10'h3FF, 10'h001, 12'hABC, 1'b0, acc);
    wait_idle("set_pixel");
    checks++;
    if (seenQ.size() != 5) begin
      failures++; $display("[TB] FAIL set_pixel_count: got %0d bytes want 5", seenQ.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seenQ[i] !== golden[i]) begin
          failures++; $display("[TB] FAIL set_pixel_b%0d: got %h want %h", i, seenQ[i], golden[i]);
        end
      end
    end
  endtask

  task automatic test_random_cmds();
    int acc;
    for (int n = 0; n < 8; n++) begin
      riseDelay = $urandom_range(1, 4);
      fallDelay = $urandom_range(1, 3);
      clear_queues();
      issue_cmd(1'($urandom_range(0, 1)), 8'($urandom), 10'($urandom), 10'($urandom),
                12'($urandom), 1'b0, acc);
      wait_idle("random");
      checks++;
      if (seenQ.size() != expQ.size()) begin
        failures++; $display("[TB] FAIL random%0d_count: got %0d want %0d", n, seenQ.size(), expQ.size());
      end else begin
        for (int i = 0; i < expQ.size(); i++) begin
          checks++;
          if (seenQ[i] !== expQ[i]) begin
            failures++; $display("[TB] FAIL random%0d_b%0d: got %h want %h", n, i, seenQ[i], expQ[i]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc[4];
    int wantGap[3];
    wantGap = '{7, 7, 16};
    riseDelay = 1; fallDelay = 1;
    clear_queues();
    unstable = 0; weMismatch = 0;
    issue_cmd(1'b0, 8'h11, 10'h0, 10'h0, 12'h0, 1'b1, acc[0]);
    issue_cmd(1'b0, 8'h22, 10'h0, 10'h0, 12'h0, 1'b1, acc[1]);
    issue_cmd(1'b1, 8'h00, 10'($urandom), 10'($urandom), 12'($urandom), 1'b1, acc[2]);
    issue_cmd(1'b0, 8'h44, 10'h0, 10'h0, 12'h0, 1'b0, acc[3]);
    wait_idle("b2b");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc[i+1] - acc[i] != wantGap[i]) begin
        failures++; $display("[TB] FAIL b2b_gap%0d: got %0d cycles want %0d", i, acc[i+1] - acc[i], wantGap[i]);
      end
    end
    checks++;
    if (seenQ.size() != expQ.size()) begin
      failures++; $display("[TB] FAIL b2b_count: got %0d want %0d", seenQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (seenQ[i] !== expQ[i]) begin
          failures++; $display("[TB] FAIL b2b_b%0d: got %h want %h", i, seenQ[i], expQ[i]);
        end
      end
    end
    checks++; if (unstable != 0) begin failures++; $display("[TB] FAIL b2b_data_stable: got %0d changes want 0", unstable); end
    checks++; if (weMismatch != 0) begin failures++; $display("[TB] FAIL b2b_we_eq_en: got %0d differences want 0", weMismatch); end
  endtask

  task automatic test_ack_high();
    int acc;
    int base;
    riseDelay = 1; fallDelay = 1;
    clear_queues();
    ackForceHigh = 1'b1;
    repeat (2) @(negedge clk);
    base = enRises;
    issue_cmd(1'b0, 8'h5A, 10'h0, 10'h0, 12'h0, 1'b0, acc);
    repeat (8) @(negedge clk);
    #1;
    checks++; if (enRises != base + 1) begin failures++; $display("[TB] FAIL ack_high_sends: got %0d want 1", enRises - base); end
    checks++; if (en !== 1'b0) begin failures++; $display("[TB] FAIL ack_high_en: got %b want 0", en); end
    ackForceHigh = 1'b0;
    wait_idle("ack_high");
    checks++;
    if (seenQ.size() != 2) begin
      failures++; $display("[TB] FAIL ack_high_count: got %0d want 2", seenQ.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (seenQ[i] !== expQ[i]) begin
          failures++; $display("[TB] FAIL ack_high_b%0d: got %h want %h", i, seenQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    int base;
    bit reached = 1'b0;
    riseDelay = 4; fallDelay = 1;
    clear_queues();
    base = enRises;
    issue_cmd(1'b1, 8'h00, 10'($urandom), 10'($urandom), 12'($urandom), 1'b0, acc);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (enRises >= base + 3) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin failures++; $display("[TB] FAIL reset_mid_reach: got %0d bytes want 3", enRises - base); end
    @(negedge clk);
    checks++; if (en !== 1'b1) begin failures++; $display("[TB] FAIL reset_mid_wait_hi_en: got %b want 1", en); end
    rstN = 1'b0;
    @(negedge clk);
    checks++; if (en !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_en: got %b want 0", en); end
    checks++; if (we !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_we: got %b want 0", we); end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_mid_ready: got %b want 1", cmdReady); end
    repeat (20) @(negedge clk);
    #1;
    checks++; if (enRises != base + 3) begin failures++; $display("[TB] FAIL reset_mid_residual: got %0d bytes want 3", enRises - base); end
    checks++;
    if (seenQ.size() != 3) begin
      failures++; $display("[TB] FAIL reset_mid_count: got %0d want 3", seenQ.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seenQ[i] !== expQ[i]) begin
          failures++; $display("[TB] FAIL reset_mid_b%0d: got %h want %h", i, seenQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int acc;
    int hiCycles = 0;
    ackNever = 1'b1;
    clear_queues();
    issue_cmd(1'b0, 8'h77, 10'h0, 10'h0, 12'h0, 1'b0, acc);
`ifdef GPU_TX_TIMEOUT_EN
    for (int i = 0; i < 100; i++) begin
      if (en !== 1'b1) break;
      hiCycles++;
      @(negedge clk);
    end
    checks++; if (hiCycles != 17) begin failures++; $display("[TB] FAIL timeout_en_cycles: got %0d want 17", hiCycles); end
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err: got %b want 1", err); end
    checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL timeout_ready: got %b want 1", cmdReady); end
    repeat (10) @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err_sticky: got %b want 1", err); end
`else
    repeat (40) @(negedge clk);
    checks++; if (en !== 1'b1) begin failures++; $display("[TB] FAIL wait_forever_en: got %b want 1", en); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL wait_forever_err: got %b want 0", err); end
    checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL wait_forever_ready: got %b want 0", cmdReady); end
    hiCycles = 0;
`endif
    ackNever = 1'b0;
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL timeout_err_cleared: got %b want 0", err); end
    rstN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_set_mode();
    test_set_pixel();
    test_random_cmds();
    test_back_to_back();
    test_ack_high();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
